vending_txn_controller: RTL



---
 rtl/vending_txn_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vending_txn_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vending_txn_controller: running total, inactivity timer, change return.   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module vending_txn_controller #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_CYCLES = 10,
  parameter int COIN_VAL0   = 100,
  parameter int COIN_VAL1   = 500,
  parameter int COIN_VAL2   = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] dp_total_nxt,
  input  logic [NUM_ITEMS-1:0]  dp_output_item,
  output logic [NUM_COINS-1:0]  o_dp_input_coin,
  output logic [NUM_ITEMS-1:0]  o_dp_select_item,
  output logic [TOTAL_BITS-1:0] o_current_total,
  output logic [NUM_ITEMS-1:0]  o_output_item,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_residue_err
);

  localparam int                 TIMER_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] c_WAIT  = TIMER_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TOTAL_BITS-1:0] total_q, total_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_ITEMS-1:0]  out_item_q, out_item_d;
  logic                  residue_q, residue_d;

  logic                  w_in_return;
  logic                  w_event;
  logic [NUM_COINS-1:0]  w_ret_coin;
  logic [TOTAL_BITS-1:0] w_ret_val;

  function automatic logic [TOTAL_BITS-1:0] coin_val(input int idx);
    case (idx)
      0:       coin_val = TOTAL_BITS'(COIN_VAL0);
      1:       coin_val = TOTAL_BITS'(COIN_VAL1);
      default: coin_val = TOTAL_BITS'(COIN_VAL2);
    endcase
  endfunction

  assign w_in_return = (state_q == ST_RETURN);
  assign w_event     = !w_in_return && ((i_input_coin != '0) || (dp_output_item != '0));

  // Gated while reset is held so nothing leaks to the datapath before release.
  assign o_dp_input_coin  = (reset_n && !w_in_return) ? i_input_coin  : '0;
  assign o_dp_select_item = (reset_n && !w_in_return) ? i_select_item : '0;

  // Coin values ascend, so the last one that fits is the largest payable coin.
  always_comb begin
    w_ret_coin = '0;
    w_ret_val  = '0;
    if (w_in_return) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (total_q >= coin_val(i)) begin
          w_ret_coin    = '0;
          w_ret_coin[i] = 1'b1;
          w_ret_val     = coin_val(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    timer_d    = timer_q;
    out_item_d = out_item_q;
    residue_d  = residue_q;
    case (state_q)
      ST_IDLE: begin
        total_d    = dp_total_nxt;
        out_item_d = dp_output_item;
        if (w_event) timer_d = c_WAIT;
        if (dp_total_nxt != '0) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        total_d    = dp_total_nxt;
        out_item_d = dp_output_item;
        if (w_event)               timer_d = c_WAIT;
        else if (timer_q != '0)    timer_d = timer_q - 1'b1;
        if (i_trigger_return)                  state_d = ST_RETURN;
        else if (dp_total_nxt == '0)           state_d = ST_IDLE;
        else if (timer_q == '0 && !w_event)    state_d = ST_RETURN;
      end
      ST_RETURN: begin
        out_item_d = '0;
        if (total_q == '0) begin
          state_d = ST_IDLE;
        end else if (total_q < coin_val(0)) begin
          total_d   = '0;
          residue_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          total_d = total_q - w_ret_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      timer_q    <= '0;
      out_item_q <= '0;
      residue_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      timer_q    <= timer_d;
      out_item_q <= out_item_d;
      residue_q  <= residue_d;
    end
  end

  assign o_current_total = total_q;
  assign o_output_item   = out_item_q;
  assign o_return_coin   = w_ret_coin;
  assign o_busy          = w_in_return;
  assign o_residue_err   = residue_q;

endmodule
`default_nettype wire
